stereo_frame_sched: RTL

Stereo input scheduler placed in front of Fea_Pro. It shares Fea_Pro's single pixel input port between a left-camera source and a right-camera source. For each frame it forwards one complete left image and then one complete right image, with a mandatory idle gap before each image. It then waits for Fea_Pro's `done` before starting the next frame.

---
 rtl/stereo_frame_sched_pkg.sv | 31 +++
 rtl/stereo_frame_sched_img_pix_counter.sv | 38 +++
 rtl/stereo_frame_sched.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/stereo_frame_sched_pkg.sv
// +--------------------------------------------------------------------------+
// | Package  : stereo_pkg                                                    |
// | Purpose  : Shared types and constants for the stereo frame scheduler.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

package stereo_pkg;

  // Scheduler states; six used codes in a 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GAP_L     = 3'd1,
    ST_LEFT      = 3'd2,
    ST_GAP_R     = 3'd3,
    ST_RIGHT     = 3'd4,
    ST_WAIT_DONE = 3'd5
  } sched_state_t;

  // Encoding of the side output.
  localparam logic SIDE_L = 1'b0;
  localparam logic SIDE_R = 1'b1;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/stereo_frame_sched_img_pix_counter.sv
// +--------------------------------------------------------------------------+
// | Module   : img_pix_counter                                               |
// | Purpose  : Loadable up-counter with a terminal-count flag. Used for      |
// |            pixel counting, gap timing and the optional watchdog.         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module img_pix_counter #(
  parameter int              WIDTH  = 8,
  parameter logic [WIDTH-1:0] TC_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,       // synchronous, active low
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  // Load has priority over increment so a restart always wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == TC_VAL);

endmodule

`default_nettype wire

// File: rtl/stereo_frame_sched.sv
// +--------------------------------------------------------------------------+
// | Module   : stereo_frame_sched                                            |
// | Purpose  : Shares one Fea_Pro pixel port between a left and a right      |
// |            camera: gap, left image, gap, right image, wait for done.     |
// | Options  : STEREO_TIMEOUT_EN - adds a WAIT_DONE watchdog and sticky      |
// |            timeout_err flag; without it timeout_err is tied low.         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
`default_nettype none

module stereo_frame_sched
  import stereo_pkg::*;
#(
  parameter int IMG_HEIGHT     = 100,
  parameter int IMG_WIDTH      = 120,
  parameter int GAP_CYCLES     = 1000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic        clk,
  input  logic        rst,          // synchronous, active low
  input  logic        enable,
  input  logic [7:0]  l_din,
  input  logic        l_valid,
  output logic        l_ready,
  input  logic [7:0]  r_din,
  input  logic        r_valid,
  output logic        r_ready,
  output logic [7:0]  img_din,
  output logic        img_din_valid,
  input  logic        fea_done,
  output logic        busy,
  output logic        side,
  output logic [15:0] frame_cnt,
  output logic        timeout_err
);

  localparam int NUM_PIX = IMG_HEIGHT * IMG_WIDTH;
  localparam int PIX_W   = cnt_width(NUM_PIX);
  localparam int GAP_W   = cnt_width(GAP_CYCLES + 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NUM_PIX - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  sched_state_t state, state_nxt;

  logic l_acc, r_acc;
  logic in_gap, in_img;
  logic pix_tc, gap_tc;
  logic wd_expire;

  assign l_acc  = l_valid && l_ready;
  assign r_acc  = r_valid && r_ready;
  assign in_gap = (state == ST_GAP_L) || (state == ST_GAP_R);
  assign in_img = (state == ST_LEFT)  || (state == ST_RIGHT);

  // Pixel counter is held at zero through each gap, so every image starts from 0.
  img_pix_counter #(
    .WIDTH  (PIX_W),
    .TC_VAL (PIX_LAST)
  ) u_pix_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (!in_img),
    .load_val ('0),
    .inc      (l_acc || r_acc),
    .tc       (pix_tc)
  );

  // Gap counter runs only inside GAP_L/GAP_R; tc marks the last gap cycle.
  img_pix_counter #(
    .WIDTH  (GAP_W),
    .TC_VAL (GAP_LAST)
  ) u_gap_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (!in_gap),
    .load_val ('0),
    .inc      (in_gap),
    .tc       (gap_tc)
  );

`ifdef STEREO_TIMEOUT_EN
  localparam int WD_W = cnt_width(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic wd_tc;

  img_pix_counter #(
    .WIDTH  (WD_W),
    .TC_VAL (WD_LAST)
  ) u_wd_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (state != ST_WAIT_DONE),
    .load_val ('0),
    .inc      (state == ST_WAIT_DONE),
    .tc       (wd_tc)
  );

  // A done arriving in the expiry cycle still completes the frame normally.
  assign wd_expire = (state == ST_WAIT_DONE) && wd_tc && !fea_done;

  // Sticky watchdog flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      timeout_err <= 1'b0;
    end else if (wd_expire) begin
      timeout_err <= 1'b1;
    end
  end
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt = state;
    l_ready   = 1'b0;
    r_ready   = 1'b0;
    busy      = 1'b1;
    side      = SIDE_L;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (enable) state_nxt = ST_GAP_L;
      end
      ST_GAP_L: begin
        if (gap_tc) state_nxt = ST_LEFT;
      end
      ST_LEFT: begin
        l_ready = 1'b1;
        if (l_acc && pix_tc) state_nxt = ST_GAP_R;
      end
      ST_GAP_R: begin
        side = SIDE_R;
        if (gap_tc) state_nxt = ST_RIGHT;
      end
      ST_RIGHT: begin
        side    = SIDE_R;
        r_ready = 1'b1;
        if (r_acc && pix_tc) state_nxt = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        side = SIDE_R;
        if (fea_done || wd_expire) state_nxt = ST_IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // One-cycle registered pixel path; img_din holds its value when idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      img_din       <= '0;
      img_din_valid <= 1'b0;
    end else begin
      img_din_valid <= l_acc || r_acc;
      if (l_acc) begin
        img_din <= l_din;
      end else if (r_acc) begin
        img_din <= r_din;
      end
    end
  end

  // Completed-frame counter, wrapping naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_cnt <= '0;
    end else if ((state == ST_WAIT_DONE) && fea_done) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

`default_nettype wire
